// File: rtl/debounce_pkg.sv
// Shared types for the multi-bit debouncer: per-bit stability FSM states and
// the glitch-counter width used when DEBOUNCE_GLITCH_CNT_EN is defined.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } db_state_e;

    localparam int GLITCH_CNT_W = 8;

endpackage

// File: rtl/debounce_bit.sv
// One debounced bit: 2-flop synchronizer followed by a stability FSM that only
// accepts a new level after STABLE_CYCLES identical synchronized samples.
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic busy,
    output logic abort
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_p1;
    logic             sync_p2;
    db_state_e        state;
    db_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dout_nxt;

    // Synchronizer stages: only sync_p2 is ever seen by the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p1 <= din;
            sync_p2 <= sync_p1;
        end
    end

    // Stability FSM state, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            dout  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dout  <= dout_nxt;
            busy  <= (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        abort     = 1'b0;
        case (state)
            STABLE_LOW: begin
                if (sync_p2) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (sync_p2) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = STABLE_HIGH;
                        dout_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end else begin
                    state_nxt = STABLE_LOW;
                    cnt_nxt   = '0;
                    abort     = 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!sync_p2) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (!sync_p2) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt = STABLE_LOW;
                        dout_nxt  = 1'b0;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end else begin
                    state_nxt = STABLE_HIGH;
                    cnt_nxt   = '0;
                    abort     = 1'b1;
                end
            end
            default: begin
                state_nxt = STABLE_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/multi_bit_debouncer.sv
// WIDTH independent debounced bits. Defining DEBOUNCE_GLITCH_CNT_EN adds a
// saturating glitch_cnt that counts clocks on which any bit aborted a WAIT state.
module multi_bit_debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        sig_in,
    output logic [WIDTH-1:0]        sig_out,
    output logic [WIDTH-1:0]        busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
        $error("multi_bit_debouncer: STABLE_CYCLES must be within 2..255");
    end

    logic [WIDTH-1:0] abort;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_bit (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (sig_in[i]),
            .dout (sig_out[i]),
            .busy (busy[i]),
            .abort(abort[i])
        );
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Several bits aborting on the same clock still count as one glitch event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if ((|abort) && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + GLITCH_CNT_W'(1);
        end
    end
`else
    logic unused_abort_any;
    assign unused_abort_any = |abort;
`endif

endmodule

// File: tb/tb_multi_bit_debouncer.sv
// Directed bench for multi_bit_debouncer (WIDTH=32, STABLE_CYCLES=4); glitch
// counter checks are active when DEBOUNCE_GLITCH_CNT_EN is defined.
module tb_multi_bit_debouncer;

    logic        clk;
    logic        rst_n;
    logic [31:0] sig_in;
    logic [31:0] sig_out;
    logic [31:0] busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0]  glitch_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    multi_bit_debouncer #(
        .WIDTH        (32),
        .STABLE_CYCLES(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .sig_out(sig_out),
        .busy   (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        sig_in = 32'hFFFF_FFFF;
        step(3);
        n_cmp++;
        if (sig_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_sig_out: got %h expected %h", sig_out, 32'h0);
        end
        n_cmp++;
        if (busy !== 32'h0) begin
            n_fail++; $display("FAIL reset_busy: got %h expected %h", busy, 32'h0);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (glitch_cnt !== 8'h00) begin
            n_fail++; $display("FAIL reset_glitch: got %h expected %h", glitch_cnt, 8'h00);
        end
`endif
        rst_n = 1'b1;
        step(3);
        n_cmp++;
        if (busy !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL rise_busy: got %h expected %h", busy, 32'hFFFF_FFFF);
        end
        step(2);
        n_cmp++;
        if (sig_out !== 32'h0) begin
            n_fail++; $display("FAIL rise_edge4: got %h expected %h", sig_out, 32'h0);
        end
        step(1);
        n_cmp++;
        if (sig_out !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL rise_edge5: got %h expected %h", sig_out, 32'hFFFF_FFFF);
        end
        n_cmp++;
        if (busy !== 32'h0) begin
            n_fail++; $display("FAIL rise_busy_done: got %h expected %h", busy, 32'h0);
        end
        sig_in = 32'h0;
        step(8);
        n_cmp++;
        if (sig_out !== 32'h0) begin
            n_fail++; $display("FAIL fall_settle: got %h expected %h", sig_out, 32'h0);
        end
    endtask

    task automatic test_glitch;
        for (int len = 1; len <= 3; len++) begin
            int busy_cycles;
            int out_high;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            logic [7:0] g0;
            g0 = glitch_cnt;
`endif
            busy_cycles = 0;
            out_high    = 0;
            sig_in[0]   = 1'b1;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (k == len - 1) sig_in[0] = 1'b0;
                if (busy[0]) busy_cycles++;
                if (sig_out[0]) out_high++;
            end
            n_cmp++;
            if (out_high !== 0) begin
                n_fail++; $display("FAIL glitch%0d_out: got %0d high cycles expected 0", len, out_high);
            end
            n_cmp++;
            if (busy_cycles !== len) begin
                n_fail++; $display("FAIL glitch%0d_busy: got %0d cycles expected %0d", len, busy_cycles, len);
            end
`ifdef DEBOUNCE_GLITCH_CNT_EN
            n_cmp++;
            if (glitch_cnt !== g0 + 8'd1) begin
                n_fail++; $display("FAIL glitch%0d_cnt: got %0d expected %0d", len, glitch_cnt, g0 + 8'd1);
            end
`endif
        end
    endtask

    task automatic test_wide;
        logic [31:0] prev;
        int          nchg;
        prev   = sig_out;
        nchg   = 0;
        sig_in = 32'hA5A5_0000;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (sig_out !== prev) nchg++;
            prev = sig_out;
            if (k == 5) begin
                n_cmp++;
                if (sig_out !== 32'h0) begin
                    n_fail++; $display("FAIL wide_edge4: got %h expected %h", sig_out, 32'h0);
                end
            end
            if (k == 6) begin
                n_cmp++;
                if (sig_out !== 32'hA5A5_0000) begin
                    n_fail++; $display("FAIL wide_edge5: got %h expected %h", sig_out, 32'hA5A5_0000);
                end
            end
        end
        n_cmp++;
        if (nchg !== 1) begin
            n_fail++; $display("FAIL wide_changes: got %0d expected 1", nchg);
        end
    endtask

    task automatic test_indep;
        sig_in = 32'h0;
        step(8);
        sig_in[1] = 1'b1;
        step(2);
        sig_in[2] = 1'b1;
        step(4);
        n_cmp++;
        if (sig_out[2:1] !== 2'b01) begin
            n_fail++; $display("FAIL indep_bit1: got %b expected %b", sig_out[2:1], 2'b01);
        end
        step(1);
        n_cmp++;
        if (sig_out[2:1] !== 2'b01) begin
            n_fail++; $display("FAIL indep_bit2_early: got %b expected %b", sig_out[2:1], 2'b01);
        end
        step(1);
        n_cmp++;
        if (sig_out[2:1] !== 2'b11) begin
            n_fail++; $display("FAIL indep_bit2: got %b expected %b", sig_out[2:1], 2'b11);
        end
    endtask

    task automatic test_toggle;
        int drops;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        logic [7:0] g0;
`endif
        sig_in = 32'h1;
        step(8);
        n_cmp++;
        if (sig_out !== 32'h1) begin
            n_fail++; $display("FAIL toggle_start: got %h expected %h", sig_out, 32'h1);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        g0 = glitch_cnt;
`endif
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            sig_in[0] = (i % 2 == 1);
            @(negedge clk);
            if (sig_out[0] !== 1'b1) drops++;
        end
        sig_in[0] = 1'b1;
        step(6);
        n_cmp++;
        if (drops !== 0) begin
            n_fail++; $display("FAIL toggle_hold: got %0d low cycles expected 0", drops);
        end
        n_cmp++;
        if (sig_out !== 32'h1) begin
            n_fail++; $display("FAIL toggle_end: got %h expected %h", sig_out, 32'h1);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (glitch_cnt !== g0 + 8'd10) begin
            n_fail++; $display("FAIL toggle_cnt: got %0d expected %0d", glitch_cnt, g0 + 8'd10);
        end
`endif
    endtask

    task automatic test_reset_mid;
        sig_in = 32'hFFFF_0000;
        step(8);
        n_cmp++;
        if (sig_out !== 32'hFFFF_0000) begin
            n_fail++; $display("FAIL mid_pre_out: got %h expected %h", sig_out, 32'hFFFF_0000);
        end
        sig_in[0] = 1'b1;
        step(4);
        n_cmp++;
        if (busy !== 32'h1) begin
            n_fail++; $display("FAIL mid_pre_busy: got %h expected %h", busy, 32'h1);
        end
        #20;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (sig_out !== 32'h0) begin
            n_fail++; $display("FAIL mid_async_out: got %h expected %h", sig_out, 32'h0);
        end
        n_cmp++;
        if (busy !== 32'h0) begin
            n_fail++; $display("FAIL mid_async_busy: got %h expected %h", busy, 32'h0);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (glitch_cnt !== 8'h00) begin
            n_fail++; $display("FAIL mid_async_glitch: got %h expected %h", glitch_cnt, 8'h00);
        end
`endif
        step(2);
        sig_in = 32'h0;
        rst_n  = 1'b1;
        step(8);
        n_cmp++;
        if (sig_out !== 32'h0) begin
            n_fail++; $display("FAIL mid_after_out: got %h expected %h", sig_out, 32'h0);
        end
    endtask

    task automatic test_saturate;
        int out_high;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        int         wraps;
        logic [7:0] prev;
`endif
        @(negedge clk);
        rst_n  = 1'b0;
        sig_in = 32'h0;
        step(2);
        rst_n = 1'b1;
        step(2);
        out_high = 0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        wraps = 0;
        prev  = glitch_cnt;
`endif
        for (int i = 0; i < 620; i++) begin
            sig_in[0] = (i % 2 == 0);
            @(negedge clk);
            if (sig_out[0]) out_high++;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            if (glitch_cnt < prev) wraps++;
            prev = glitch_cnt;
`endif
        end
        sig_in[0] = 1'b0;
        step(6);
        n_cmp++;
        if (out_high !== 0) begin
            n_fail++; $display("FAIL sat_out: got %0d high cycles expected 0", out_high);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (wraps !== 0) begin
            n_fail++; $display("FAIL sat_wrap: got %0d decreases expected 0", wraps);
        end
        n_cmp++;
        if (glitch_cnt !== 8'hFF) begin
            n_fail++; $display("FAIL sat_value: got %h expected %h", glitch_cnt, 8'hFF);
        end
`endif
    endtask

    initial begin
        rst_n  = 1'b0;
        sig_in = 32'h0;
        test_reset;
        test_glitch;
        test_wide;
        test_indep;
        test_toggle;
        test_reset_mid;
        test_saturate;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
